// File: rtl/matrix_pkg.sv
// Shared constants for the matrix ALU feeder: opcodes, sizes, loader states, error codes.
// Element (row,col) lives at bit offset (row*MAX_DIM+col)*ELEM_W of a packed operand bus.
package matrix_pkg;

  localparam int MAX_DIM = 5;
  localparam int ELEM_W  = 8;
  localparam int MAT_W   = MAX_DIM * MAX_DIM * ELEM_W;

  localparam logic [3:0] OP_SOMA    = 4'b0011;
  localparam logic [3:0] OP_SUB     = 4'b0100;
  localparam logic [3:0] OP_MULT    = 4'b0101;
  localparam logic [3:0] OP_TRANSP  = 4'b0110;
  localparam logic [3:0] OP_OPOSTA  = 4'b0111;
  localparam logic [3:0] OP_ESCALAR = 4'b1000;
  localparam logic [3:0] OP_DET2    = 4'b1001;
  localparam logic [3:0] OP_DET3    = 4'b1010;
  localparam logic [3:0] OP_DET4    = 4'b1011;
  localparam logic [3:0] OP_DET5    = 4'b1100;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SCALAR = 3'd1;
  localparam state_t ST_LOAD_A = 3'd2;
  localparam state_t ST_LOAD_B = 3'd3;
  localparam state_t ST_ISSUE  = 3'd4;
  localparam state_t ST_WAIT   = 3'd5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_OPCODE  = 2'b01;
  localparam logic [1:0] ERR_SIZE    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  function automatic int unsigned elem_off(input logic [2:0] row, input logic [2:0] col);
    return ((32'(row) * 32'(MAX_DIM)) + 32'(col)) * 32'(ELEM_W);
  endfunction

endpackage

// File: rtl/matrix_elem_counter.sv
// Row-major row/col walker over an n x n region; clear has priority over advance.
// last flags the final element (n-1,n-1) combinationally from the current position.
module matrix_elem_counter
  import matrix_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  input  logic [2:0] n,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       last
);

  logic [2:0] n_m1;
  assign n_m1 = n - 3'd1;
  assign last = (row == n_m1) && (col == n_m1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      row <= 3'd0;
      col <= 3'd0;
    end else if (advance) begin
      if (col == n_m1) begin
        col <= 3'd0;
        row <= row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Byte-stream front end for the matrix ALU: decodes a header, loads scalar/A/B, pulses start, waits for done.
// Optional WAIT watchdog is compiled in with LOADER_TIMEOUT_EN.
module matrix_loader #(
  parameter int MAX_DIM        = 5,
  parameter int ELEM_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [7:0]                        in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] matriz_a,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] matriz_b,
  output logic [3:0]                        opcode,
  output logic [7:0]                        data_escalar,
  output logic                              alu_start,
  input  logic                              alu_done,
  output logic                              busy,
  output logic                              error,
  output logic [1:0]                        err_code
);

  import matrix_pkg::*;

  state_t     state;
  logic [3:0] op_lat;
  logic [2:0] n_lat;
  logic       wait_first;

  logic       xfer;
  logic [3:0] hdr_op;
  logic [2:0] hdr_n;
  logic       op_ok;
  logic       size_ok;
  logic       needs_b;
  logic [2:0] row;
  logic [2:0] col;
  logic       last;
  logic       cnt_clear;
  logic       cnt_adv;
  logic       unused_hdr_bit;

  assign in_ready = (state == ST_IDLE) || (state == ST_SCALAR) ||
                    (state == ST_LOAD_A) || (state == ST_LOAD_B);
  assign xfer     = in_valid && in_ready;

  assign hdr_op         = in_data[3:0];
  assign unused_hdr_bit = in_data[7];
  assign op_ok          = (hdr_op >= OP_SOMA) && (hdr_op <= OP_DET5);

  // Determinant opcodes imply their own order regardless of the header n field.
  always_comb begin
    hdr_n = in_data[6:4];
    case (hdr_op)
      OP_DET2: hdr_n = 3'd2;
      OP_DET3: hdr_n = 3'd3;
      OP_DET4: hdr_n = 3'd4;
      OP_DET5: hdr_n = 3'd5;
      default: hdr_n = in_data[6:4];
    endcase
  end

  assign size_ok = (hdr_n >= 3'd2) && (hdr_n <= 3'(MAX_DIM));
  assign needs_b = (op_lat == OP_SOMA) || (op_lat == OP_SUB) || (op_lat == OP_MULT);

  assign cnt_clear = ((state != ST_LOAD_A) && (state != ST_LOAD_B)) ||
                     ((state == ST_LOAD_A) && xfer && last);
  assign cnt_adv   = xfer && ((state == ST_LOAD_A) || (state == ST_LOAD_B));

  matrix_elem_counter u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .advance (cnt_adv),
    .n       (n_lat),
    .row     (row),
    .col     (col),
    .last    (last)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      op_lat       <= 4'd0;
      n_lat        <= 3'd0;
      wait_first   <= 1'b0;
      matriz_a     <= '0;
      matriz_b     <= '0;
      opcode       <= 4'd0;
      data_escalar <= 8'd0;
      alu_start    <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
`ifdef LOADER_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      alu_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            if (!op_ok) begin
              error    <= 1'b1;
              err_code <= ERR_OPCODE;
            end else if (!size_ok) begin
              error    <= 1'b1;
              err_code <= ERR_SIZE;
            end else begin
              matriz_a <= '0;
              matriz_b <= '0;
              opcode   <= 4'd0;
              error    <= 1'b0;
              err_code <= ERR_NONE;
              op_lat   <= hdr_op;
              n_lat    <= hdr_n;
              busy     <= 1'b1;
              state    <= (hdr_op == OP_ESCALAR) ? ST_SCALAR : ST_LOAD_A;
            end
          end
        end
        ST_SCALAR: begin
          if (xfer) begin
            data_escalar <= in_data;
            state        <= ST_LOAD_A;
          end
        end
        ST_LOAD_A: begin
          if (xfer) begin
            matriz_a[elem_off(row, col) +: 8] <= in_data;
            if (last) begin
              if (needs_b) begin
                state <= ST_LOAD_B;
              end else begin
                state     <= ST_ISSUE;
                opcode    <= op_lat;
                alu_start <= 1'b1;
              end
            end
          end
        end
        ST_LOAD_B: begin
          if (xfer) begin
            matriz_b[elem_off(row, col) +: 8] <= in_data;
            if (last) begin
              state     <= ST_ISSUE;
              opcode    <= op_lat;
              alu_start <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          state      <= ST_WAIT;
          wait_first <= 1'b1;
`ifdef LOADER_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
        end
        ST_WAIT: begin
          wait_first <= 1'b0;
          // The first WAIT cycle may still see the previous command's registered done.
          if (!wait_first && alu_done) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
`ifdef LOADER_TIMEOUT_EN
          else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            error    <= 1'b1;
            err_code <= ERR_TIMEOUT;
            busy     <= 1'b0;
            opcode   <= 4'd0;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
